rf_write_arbiter: RTL

//  Shares the register file's single write port between NUM_REQ writeback requesters.

---
 rtl/rf_write_arbiter_if.sv | 29 ++
 rtl/rf_write_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback request, claim/hazard query and register-file write bus (slave = arbiter, master = environment)
interface rf_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      claim_valid;
  logic [ADDR_W-1:0]         claim_addr;
  logic                      claim_busy;
  logic [ADDR_W-1:0]         rd_addr_1;
  logic [ADDR_W-1:0]         rd_addr_2;
  logic                      rd_busy_1;
  logic                      rd_busy_2;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  modport slave (
    input  req_valid, req_addr, req_data, claim_valid, claim_addr, rd_addr_1, rd_addr_2,
    output req_ready, claim_busy, rd_busy_1, rd_busy_2, wr_en, wr_addr, wr_data
  );
  modport master (
    output req_valid, req_addr, req_data, claim_valid, claim_addr, rd_addr_1, rd_addr_2,
    input  req_ready, claim_busy, rd_busy_1, rd_busy_2, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port with a registered write stage and busy-bit scoreboard; ports clk, rst (async, active-high), bus (rf_write_arbiter_if.slave); RF_ARB_BYPASS_EN masks rd_busy for the register being written this cycle
module rf_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int RIDX_W = $clog2(NUM_REGS);
`ifdef RF_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [PTR_W-1:0]    ptr_q, ptr_d, gidx;
  logic                hit;
  int                  cand;
  logic [ADDR_W-1:0]   sel_addr;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, set_v, clr_v;
  logic                claim_ok, claim_in, rd1_in, rd2_in;
  // Search starts at ptr_q, which already holds last_granted+1.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    cand = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!hit && bus.req_valid[PTR_W'(cand)]) begin
        hit  = 1'b1;
        gidx = PTR_W'(cand);
      end
    end
    sel_addr  = bus.req_addr[gidx*ADDR_W +: ADDR_W];
    ptr_d     = hit ? ((int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1) : ptr_q;
    wr_en_d   = hit && sel_addr != '0 && 32'(sel_addr) < NUM_REGS;
    wr_addr_d = hit ? sel_addr : wr_addr_q;
    wr_data_d = hit ? bus.req_data[gidx*DATA_W +: DATA_W] : wr_data_q;
  end
  assign bus.req_ready = hit ? (NUM_REQ'(1) << gidx) : '0;
  assign claim_in      = 32'(bus.claim_addr) < NUM_REGS;
  assign rd1_in        = 32'(bus.rd_addr_1) < NUM_REGS;
  assign rd2_in        = 32'(bus.rd_addr_2) < NUM_REGS;
  assign bus.claim_busy = claim_in && busy_q[bus.claim_addr[RIDX_W-1:0]];
  assign bus.rd_busy_1  = rd1_in && busy_q[bus.rd_addr_1[RIDX_W-1:0]] && !(BYPASS && wr_en_q && wr_addr_q == bus.rd_addr_1);
  assign bus.rd_busy_2  = rd2_in && busy_q[bus.rd_addr_2[RIDX_W-1:0]] && !(BYPASS && wr_en_q && wr_addr_q == bus.rd_addr_2);
  assign claim_ok = bus.claim_valid && claim_in && !bus.claim_busy;
  // Set is applied after clear so a same-cycle claim wins; bit 0 is forced clear.
  always_comb begin
    set_v  = claim_ok ? (NUM_REGS'(1) << bus.claim_addr[RIDX_W-1:0]) : '0;
    clr_v  = wr_en_q ? (NUM_REGS'(1) << wr_addr_q[RIDX_W-1:0]) : '0;
    busy_d = ((busy_q & ~clr_v) | set_v) & ~NUM_REGS'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule
